kf_dt_param_gen: RTL and testbench



---
 rtl/kf_pkg.sv | 86 ++++++++
 rtl/kf_dt_param_gen_if.sv | 25 ++
 rtl/fp_multiplier.sv | 43 ++++
 rtl/kf_dt_param_gen.sv | 182 ++++++++++++++++++
 tb/tb_kf_dt_param_gen.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kf_pkg.sv
// kf_pkg: shared widths, coefficients and FSM state type for the Kalman
// covariance-prediction blocks, plus the IEEE-754 double multiply used by
// fp_multiplier.
package kf_pkg;

  localparam int DBL_WIDTH = 64;

  localparam logic [DBL_WIDTH-1:0] C_HALF  = 64'h3FE0000000000000;
  localparam logic [DBL_WIDTH-1:0] C_TWO3  = 64'h3FE5555555555555;
  localparam logic [DBL_WIDTH-1:0] C_SIXTH = 64'h3FC5555555555555;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_DT2,
    S_P2,
    S_P3,
    S_DONE
  } state_e;

  // Double-precision multiply, round-to-nearest-even. Denormal inputs are
  // treated as zero and underflowing results flush to signed zero; any NaN
  // input or Inf*0 yields the canonical quiet NaN.
  function automatic logic [DBL_WIDTH-1:0] fp_mul_f(input logic [DBL_WIDTH-1:0] x,
                                                    input logic [DBL_WIDTH-1:0] y);
    logic                 s;
    logic [10:0]          ex, ey;
    logic [51:0]          mx, my;
    logic                 nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
    logic [105:0]         p;
    logic [52:0]          m;
    logic                 g, st;
    logic [53:0]          mr;
    logic [51:0]          frac;
    logic signed [13:0]   e;
    logic [DBL_WIDTH-1:0] r;

    s  = x[63] ^ y[63];
    ex = x[62:52];
    ey = y[62:52];
    mx = x[51:0];
    my = y[51:0];

    nan_x  = (ex == 11'h7FF) && (mx != 52'd0);
    nan_y  = (ey == 11'h7FF) && (my != 52'd0);
    inf_x  = (ex == 11'h7FF) && (mx == 52'd0);
    inf_y  = (ey == 11'h7FF) && (my == 52'd0);
    zero_x = (ex == 11'h000);
    zero_y = (ey == 11'h000);

    p = 106'({1'b1, mx}) * 106'({1'b1, my});
    e = $signed(14'(ex)) + $signed(14'(ey)) - 14'sd1023;

    // Product of two [1,2) significands lies in [1,4); renormalise to [1,2).
    if (p[105]) begin
      m  = p[105:53];
      g  = p[52];
      st = |p[51:0];
      e  = e + 14'sd1;
    end else begin
      m  = p[104:52];
      g  = p[51];
      st = |p[50:0];
    end

    mr   = {1'b0, m} + 54'(g & (st | m[0]));
    frac = mr[53] ? mr[52:1] : mr[51:0];
    e    = e + $signed(14'(mr[53]));

    if (nan_x || nan_y || (inf_x && zero_y) || (zero_x && inf_y)) begin
      r = 64'h7FF8000000000000;
    end else if (inf_x || inf_y) begin
      r = {s, 11'h7FF, 52'd0};
    end else if (zero_x || zero_y) begin
      r = {s, 63'd0};
    end else if (e >= 14'sd2047) begin
      r = {s, 11'h7FF, 52'd0};
    end else if (e <= 14'sd0) begin
      r = {s, 63'd0};
    end else begin
      r = {s, e[10:0], frac};
    end
    return r;
  endfunction

endpackage

// File: rtl/kf_dt_param_gen_if.sv
// kf_dt_param_gen_if: request/result bundle between a dt source and the
// powers-of-dt generator.
interface kf_dt_param_gen_if;
  import kf_pkg::*;

  logic                 start;
  logic [DBL_WIDTH-1:0] dt_in;
  logic                 busy;
  logic [DBL_WIDTH-1:0] delta_t;
  logic [DBL_WIDTH-1:0] half_dt2;
  logic [DBL_WIDTH-1:0] two3_dt3;
  logic [DBL_WIDTH-1:0] sixth_dt3;
  logic                 valid_out;

  modport master (
    output start, dt_in,
    input  busy, delta_t, half_dt2, two3_dt3, sixth_dt3, valid_out
  );

  modport slave (
    input  start, dt_in,
    output busy, delta_t, half_dt2, two3_dt3, sixth_dt3, valid_out
  );

endinterface

// File: rtl/fp_multiplier.sv
// fp_multiplier: multi-cycle double multiplier with a go/ready/finish
// handshake. Operands are sampled on an accepted go; finish pulses for one
// cycle LATENCY-1 cycles later with the product on result. A new go is
// accepted in the finish cycle so back-to-back use loses no cycle.
module fp_multiplier
  import kf_pkg::*;
#(
  parameter int unsigned LATENCY = 4  // >= 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [DBL_WIDTH-1:0] a,
  input  logic [DBL_WIDTH-1:0] b,
  output logic                 ready,
  output logic                 finish,
  output logic [DBL_WIDTH-1:0] result
);

  logic [7:0] cnt;
  logic       active;

  assign finish = active && (cnt == 8'd0);
  assign ready  = !active || finish;

  // Down-counter from go to terminal count; product held until next go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= 8'd0;
      result <= '0;
    end else if (go && ready) begin
      active <= 1'b1;
      cnt    <= 8'(LATENCY - 2);
      result <= fp_mul_f(a, b);
    end else if (finish) begin
      active <= 1'b0;
    end else if (active) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/kf_dt_param_gen.sv
// kf_dt_param_gen: turns one sample interval dt into delta_t, 0.5*dt^2,
// (2/3)*dt^3 and (1/6)*dt^3 using two shared multipliers. Results are held
// until the next computation completes; a repeated dt (bit-equal) skips the
// multipliers entirely.
//
//   state  | meaning
//   S_IDLE | waiting for start, dt captured on start
//   S_CHK  | compare dt against last computed dt
//   S_DT2  | mul0: dt*dt
//   S_P2   | mul0: dt2*0.5, mul1: dt2*dt (wait for both)
//   S_P3   | mul0: dt3*2/3, mul1: dt3*1/6 (wait for both)
//   S_DONE | publish results (miss only), pulse done
module kf_dt_param_gen
  import kf_pkg::*;
#(
  parameter int unsigned MUL0_LAT = 4,
  parameter int unsigned MUL1_LAT = 4
) (
  input logic              clk,
  input logic              rst,
  kf_dt_param_gen_if.slave bus
);

  state_e state, state_nxt;

  logic [DBL_WIDTH-1:0] dt_r, dt2, dt3, half_r, two3_r, sixth_r, dt_last;
  logic [DBL_WIDTH-1:0] delta_t_q, half_dt2_q, two3_dt3_q, sixth_dt3_q;
  logic                 cache_ok, miss_r, valid_q;
  logic                 issued, fin0_seen, fin1_seen;
  logic                 both_done, cache_hit, done_pipe;

  logic                 mul0_go, mul1_go, mul0_rdy, mul1_rdy, mul0_fin, mul1_fin;
  logic [DBL_WIDTH-1:0] mul0_a, mul0_b, mul1_a, mul1_b, mul0_res, mul1_res;

  fp_multiplier #(.LATENCY(MUL0_LAT)) u_mul0 (
    .clk    (clk),
    .rst    (rst),
    .go     (mul0_go),
    .a      (mul0_a),
    .b      (mul0_b),
    .ready  (mul0_rdy),
    .finish (mul0_fin),
    .result (mul0_res)
  );

  fp_multiplier #(.LATENCY(MUL1_LAT)) u_mul1 (
    .clk    (clk),
    .rst    (rst),
    .go     (mul1_go),
    .a      (mul1_a),
    .b      (mul1_b),
    .ready  (mul1_rdy),
    .finish (mul1_fin),
    .result (mul1_res)
  );

  assign cache_hit = cache_ok && (dt_r == dt_last);
  // A finish in the current cycle counts as seen, so the join costs no cycle.
  assign both_done = (fin0_seen || mul0_fin) && (fin1_seen || mul1_fin);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, multiplier operand select and single-cycle go generation.
  always_comb begin
    state_nxt = state;
    mul0_go   = 1'b0;
    mul1_go   = 1'b0;
    mul0_a    = '0;
    mul0_b    = '0;
    mul1_a    = '0;
    mul1_b    = '0;
    done_pipe = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_CHK;
      S_CHK:  state_nxt = cache_hit ? S_DONE : S_DT2;
      S_DT2: begin
        mul0_a  = dt_r;
        mul0_b  = dt_r;
        mul0_go = !issued && mul0_rdy;
        if (issued && mul0_fin) state_nxt = S_P2;
      end
      S_P2: begin
        mul0_a  = dt2;
        mul0_b  = C_HALF;
        mul1_a  = dt2;
        mul1_b  = dt_r;
        mul0_go = !issued && mul0_rdy && mul1_rdy;
        mul1_go = !issued && mul0_rdy && mul1_rdy;
        if (issued && both_done) state_nxt = S_P3;
      end
      S_P3: begin
        mul0_a  = dt3;
        mul0_b  = C_TWO3;
        mul1_a  = dt3;
        mul1_b  = C_SIXTH;
        mul0_go = !issued && mul0_rdy && mul1_rdy;
        mul1_go = !issued && mul0_rdy && mul1_rdy;
        if (issued && both_done) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_pipe = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state issue and finish flags; cleared whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued    <= 1'b0;
      fin0_seen <= 1'b0;
      fin1_seen <= 1'b0;
    end else if (state_nxt != state) begin
      issued    <= 1'b0;
      fin0_seen <= 1'b0;
      fin1_seen <= 1'b0;
    end else begin
      if (mul0_go || mul1_go) issued <= 1'b1;
      if (issued && mul0_fin) fin0_seen <= 1'b1;
      if (issued && mul1_fin) fin1_seen <= 1'b1;
    end
  end

  // Datapath: capture dt, latch partial products, publish on done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_r        <= '0;
      dt2         <= '0;
      dt3         <= '0;
      half_r      <= '0;
      two3_r      <= '0;
      sixth_r     <= '0;
      dt_last     <= '0;
      cache_ok    <= 1'b0;
      miss_r      <= 1'b0;
      delta_t_q   <= '0;
      half_dt2_q  <= '0;
      two3_dt3_q  <= '0;
      sixth_dt3_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) dt_r <= bus.dt_in;
        S_CHK:  miss_r <= !cache_hit;
        S_DT2:  if (issued && mul0_fin) dt2 <= mul0_res;
        S_P2: begin
          if (issued && mul0_fin) half_r <= mul0_res;
          if (issued && mul1_fin) dt3    <= mul1_res;
        end
        S_P3: begin
          if (issued && mul0_fin) two3_r  <= mul0_res;
          if (issued && mul1_fin) sixth_r <= mul1_res;
        end
        S_DONE: begin
          if (miss_r) begin
            delta_t_q   <= dt_r;
            half_dt2_q  <= half_r;
            two3_dt3_q  <= two3_r;
            sixth_dt3_q <= sixth_r;
            dt_last     <= dt_r;
            cache_ok    <= 1'b1;
          end
        end
        default: ;
      endcase
      valid_q <= done_pipe;
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.valid_out = valid_q;
  assign bus.delta_t   = delta_t_q;
  assign bus.half_dt2  = half_dt2_q;
  assign bus.two3_dt3  = two3_dt3_q;
  assign bus.sixth_dt3 = sixth_dt3_q;

endmodule

// File: tb/tb_kf_dt_param_gen.sv
// tb_kf_dt_param_gen: two generators, one with matched multiplier latencies
// and one where mul1 trails mul0 by five cycles, checked against a real-number
// model of the powers-of-dt chain and a dt cache.
module tb_kf_dt_param_gen;
  import kf_pkg::*;

  localparam int unsigned LA0 = 4;
  localparam int unsigned LA1 = 4;
  localparam int unsigned LB0 = 4;
  localparam int unsigned LB1 = 9;

  localparam logic [63:0] D_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] D_TWO  = 64'h4000000000000000;
  localparam logic [63:0] D_PZ   = 64'h0000000000000000;
  localparam logic [63:0] D_NZ   = 64'h8000000000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kf_dt_param_gen_if bus_a ();
  kf_dt_param_gen_if bus_b ();

  kf_dt_param_gen #(.MUL0_LAT(LA0), .MUL1_LAT(LA1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  kf_dt_param_gen #(.MUL0_LAT(LB0), .MUL1_LAT(LB1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int go0_cnt[2] = '{0, 0};
  int go1_cnt[2] = '{0, 0};

  always @(posedge clk) begin
    if (dut_a.mul0_go) go0_cnt[0] <= go0_cnt[0] + 1;
    if (dut_a.mul1_go) go1_cnt[0] <= go1_cnt[0] + 1;
    if (dut_b.mul0_go) go0_cnt[1] <= go0_cnt[1] + 1;
    if (dut_b.mul1_go) go1_cnt[1] <= go1_cnt[1] + 1;
  end

  // Reference model state per unit: cache key and published outputs
  // (0 delta_t, 1 half_dt2, 2 two3_dt3, 3 sixth_dt3).
  logic        m_ok[2];
  logic [63:0] m_last[2];
  logic [63:0] m_out[2][4];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rmul(input logic [63:0] p, input logic [63:0] q);
    return $realtobits($bitstoreal(p) * $bitstoreal(q));
  endfunction

  function automatic int miss_latency(input int u);
    int l0, l1;
    l0 = (u == 0) ? int'(LA0) : int'(LB0);
    l1 = (u == 0) ? int'(LA1) : int'(LB1);
    // check + done + valid, one dt^2 product, then two paired products
    return 3 + l0 + 2 * ((l0 > l1) ? l0 : l1);
  endfunction

  function automatic logic [63:0] get_out(input int u, input int i);
    logic [63:0] v;
    if (u == 0) begin
      case (i)
        0:       v = bus_a.delta_t;
        1:       v = bus_a.half_dt2;
        2:       v = bus_a.two3_dt3;
        default: v = bus_a.sixth_dt3;
      endcase
    end else begin
      case (i)
        0:       v = bus_b.delta_t;
        1:       v = bus_b.half_dt2;
        2:       v = bus_b.two3_dt3;
        default: v = bus_b.sixth_dt3;
      endcase
    end
    return v;
  endfunction

  function automatic logic get_valid(input int u);
    return (u == 0) ? bus_a.valid_out : bus_b.valid_out;
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 0) ? bus_a.busy : bus_b.busy;
  endfunction

  task automatic drive(input int u, input logic s, input logic [63:0] d);
    if (u == 0) begin
      bus_a.start = s;
      bus_a.dt_in = d;
    end else begin
      bus_b.start = s;
      bus_b.dt_in = d;
    end
  endtask

  function automatic logic [63:0] rand_dt();
    logic [63:0] v;
    v[63]    = 1'($urandom);
    v[62:52] = 11'($urandom_range(1083, 963));
    v[51:32] = 20'($urandom);
    v[31:0]  = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ok[u]   = 1'b0;
      m_last[u] = '0;
      for (int i = 0; i < 4; i++) m_out[u][i] = '0;
    end
  endtask

  // One request on unit u. spam: keep start high with junk dt while busy.
  // chain: issue next_dt in the valid_out cycle. pre: start already issued
  // by a chained predecessor (caller is at the negedge of cycle 1).
  task automatic run_op(input int u, input logic [63:0] dt, input bit spam,
                        input bit chain, input logic [63:0] next_dt, input bit pre);
    logic [63:0] exp_o[4];
    logic [63:0] old_o[4];
    logic [63:0] dt2_m, dt3_m;
    logic        hit, held_ok, seen;
    int          lat_exp, k, lat, pulses, g0, g1;
    string       nm[4];
    nm[0] = "delta_t"; nm[1] = "half_dt2"; nm[2] = "two3_dt3"; nm[3] = "sixth_dt3";

    hit = m_ok[u] && (m_last[u] == dt);
    for (int i = 0; i < 4; i++) old_o[i] = m_out[u][i];
    if (hit) begin
      for (int i = 0; i < 4; i++) exp_o[i] = old_o[i];
      lat_exp = 3;
    end else begin
      dt2_m    = rmul(dt, dt);
      dt3_m    = rmul(dt2_m, dt);
      exp_o[0] = dt;
      exp_o[1] = rmul(dt2_m, C_HALF);
      exp_o[2] = rmul(dt3_m, C_TWO3);
      exp_o[3] = rmul(dt3_m, C_SIXTH);
      lat_exp  = miss_latency(u);
    end

    g0 = go0_cnt[u];
    g1 = go1_cnt[u];
    if (!pre) begin
      @(negedge clk);
      drive(u, 1'b1, dt);
      @(negedge clk);
      drive(u, spam, spam ? rand_dt() : 64'd0);
    end

    k = 1; lat = 0; pulses = 0; held_ok = 1'b1; seen = 1'b0;
    forever begin
      if (get_valid(u)) begin
        pulses++;
        if (!seen) begin
          seen = 1'b1;
          lat  = k;
          for (int i = 0; i < 4; i++)
            check_eq($sformatf("u%0d %s", u, nm[i]), get_out(u, i), exp_o[i]);
          check_eq($sformatf("u%0d busy_at_valid", u), 64'(get_busy(u)), 64'd0);
          check_eq($sformatf("u%0d latency", u), 64'(lat), 64'(lat_exp));
          check_eq($sformatf("u%0d mul0_go_count", u), 64'(go0_cnt[u] - g0), hit ? 64'd0 : 64'd3);
          check_eq($sformatf("u%0d mul1_go_count", u), 64'(go1_cnt[u] - g1), hit ? 64'd0 : 64'd2);
          drive(u, chain, chain ? next_dt : 64'd0);
        end
      end else if (!seen) begin
        for (int i = 0; i < 4; i++)
          if (get_out(u, i) !== old_o[i]) held_ok = 1'b0;
        if (get_busy(u) !== 1'b1) held_ok = 1'b0;
        if (spam) drive(u, 1'b1, rand_dt());
      end
      if (seen && chain) break;
      if (seen && k >= lat + 4) break;
      if (k >= 400) break;
      @(negedge clk);
      k++;
    end

    check_eq($sformatf("u%0d valid_seen", u), 64'(seen), 64'd1);
    check_eq($sformatf("u%0d held_while_busy", u), 64'(held_ok), 64'd1);
    if (!chain) check_eq($sformatf("u%0d valid_pulses", u), 64'(pulses), 64'd1);
    if (chain) begin
      @(negedge clk);
      drive(u, 1'b0, 64'd0);
    end

    if (!hit) begin
      m_ok[u]   = 1'b1;
      m_last[u] = dt;
      for (int i = 0; i < 4; i++) m_out[u][i] = exp_o[i];
    end
  endtask

  task automatic check_zero_state(input string tag);
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4; i++)
        check_eq($sformatf("u%0d %s out%0d", u, tag, i), get_out(u, i), 64'd0);
      check_eq($sformatf("u%0d %s busy", u, tag), 64'(get_busy(u)), 64'd0);
      check_eq($sformatf("u%0d %s valid", u, tag), 64'(get_valid(u)), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] d;
    model_reset();
    drive(0, 1'b0, 64'd0);
    drive(1, 1'b0, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_state("reset");
    rst = 1'b0;

    for (int u = 0; u < 2; u++) begin
      run_op(u, D_ONE, 1'b0, 1'b0, 64'd0, 1'b0);
      check_eq($sformatf("u%0d one half", u),  get_out(u, 1), 64'h3FE0000000000000);
      check_eq($sformatf("u%0d one two3", u),  get_out(u, 2), 64'h3FE5555555555555);
      check_eq($sformatf("u%0d one sixth", u), get_out(u, 3), 64'h3FC5555555555555);

      run_op(u, D_TWO, 1'b0, 1'b0, 64'd0, 1'b0);
      check_eq($sformatf("u%0d two half", u),  get_out(u, 1), 64'h4000000000000000);
      check_eq($sformatf("u%0d two two3", u),  get_out(u, 2), 64'h4015555555555555);
      check_eq($sformatf("u%0d two sixth", u), get_out(u, 3), 64'h3FF5555555555555);

      run_op(u, D_TWO, 1'b0, 1'b0, 64'd0, 1'b0);
      check_eq($sformatf("u%0d hit two3", u), get_out(u, 2), 64'h4015555555555555);

      run_op(u, D_PZ, 1'b0, 1'b0, 64'd0, 1'b0);
      check_eq($sformatf("u%0d zero half", u), get_out(u, 1) & 64'h7FFFFFFFFFFFFFFF, 64'd0);
      run_op(u, D_NZ, 1'b0, 1'b0, 64'd0, 1'b0);
    end

    // start held high while busy, then a start in the valid_out cycle
    run_op(0, 64'h4014000000000000, 1'b1, 1'b1, 64'h4004000000000000, 1'b0);
    run_op(0, 64'h4004000000000000, 1'b0, 1'b0, 64'd0, 1'b1);
    run_op(1, 64'h3FE8000000000000, 1'b0, 1'b1, 64'h3FE8000000000000, 1'b0);
    run_op(1, 64'h3FE8000000000000, 1'b0, 1'b0, 64'd0, 1'b1);

    // reset while unit 0 is in its paired-product phase
    @(negedge clk);
    drive(0, 1'b1, 64'h4008000000000000);
    @(negedge clk);
    drive(0, 1'b0, 64'd0);
    repeat (LA0 + 2) @(negedge clk);
    check_eq("u0 busy_before_reset", 64'(get_busy(0)), 64'd1);
    rst = 1'b1;
    #1;
    check_zero_state("midreset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_op(0, D_TWO, 1'b0, 1'b0, 64'd0, 1'b0);
    run_op(1, D_TWO, 1'b0, 1'b0, 64'd0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int u;
      u = n % 2;
      if (m_ok[u] && ($urandom_range(2, 0) == 0)) d = m_last[u];
      else                                        d = rand_dt();
      run_op(u, d, 1'b0, 1'b0, 64'd0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
